// File: rtl/stream_grant_arbiter_pkg.sv
// Shared types and helpers for the stream crossbar: arbiter state encoding and
// the id-width rule used by both the arbiter bank and the data net.
package stream_xbar_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // A one-entry index space still needs one bit so ports never collapse to zero width.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/stream_grant_arbiter_if.sv
// Request/grant bundle between the input streams, the arbiter bank and the
// crossbar data net.
interface stream_grant_arbiter_if
    import stream_xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
) ();

    localparam int T_ID___WIDTH = id_width(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = id_width(M_DATA_COUNT);

    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
    logic [S_DATA_COUNT-1:0]                   s_valid_i;
    logic [S_DATA_COUNT-1:0]                   s_last_i;
    logic [M_DATA_COUNT-1:0]                   m_ready_i;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o;
    logic [M_DATA_COUNT-1:0]                   arbiter_ready_o;
    logic [M_DATA_COUNT-1:0]                   busy_o;

    modport master (
        output s_dest_i,
        output s_valid_i,
        output s_last_i,
        output m_ready_i,
        input  grant_o,
        input  arbiter_ready_o,
        input  busy_o
    );

    modport slave (
        input  s_dest_i,
        input  s_valid_i,
        input  s_last_i,
        input  m_ready_i,
        output grant_o,
        output arbiter_ready_o,
        output busy_o
    );

endinterface

// File: rtl/stream_grant_arbiter_rr.sv
// Single-output round-robin arbiter: picks a requester, then holds the grant
// until the granted source's last beat is accepted downstream.
module rr_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    localparam int T_ID___WIDTH = id_width(S_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [S_DATA_COUNT-1:0] i_req,
    input  logic [S_DATA_COUNT-1:0] i_last_req,
    input  logic                    i_ready,
    output logic [T_ID___WIDTH-1:0] o_grant,
    output logic                    o_busy
);

    localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [T_ID___WIDTH-1:0] r_grant;
    logic [T_ID___WIDTH-1:0] w_next_grant;
    logic [T_ID___WIDTH-1:0] r_ptr;
    logic [T_ID___WIDTH-1:0] w_next_ptr;
    logic [T_ID___WIDTH-1:0] w_hi_idx;
    logic [T_ID___WIDTH-1:0] w_lo_idx;
    logic [T_ID___WIDTH-1:0] w_winner;
    logic                    w_hi_any;
    logic                    w_any;
    logic                    w_eop;

    // Round-robin search: lowest requester at or above the pointer, else lowest overall.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
            w_hi_idx = (i_req[i] && (T_ID___WIDTH'(i) >= r_ptr)) ? T_ID___WIDTH'(i) : w_hi_idx;
            w_hi_any = w_hi_any | (i_req[i] && (T_ID___WIDTH'(i) >= r_ptr));
            w_lo_idx = i_req[i] ? T_ID___WIDTH'(i) : w_lo_idx;
        end
        w_any    = |i_req;
        w_winner = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    // End of packet: the currently granted source presents its last beat and it is accepted.
    always_comb begin
        w_eop = 1'b0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            w_eop = w_eop | ((r_grant == T_ID___WIDTH'(i)) && i_last_req[i]);
        end
        w_eop = w_eop & i_ready;
    end

    // Next-state logic; grant and pointer only move when a new packet is accepted.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_ptr   = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_next_state = ARB_BUSY;
                    w_next_grant = w_winner;
                    w_next_ptr   = (w_winner == LAST_IDX) ? '0 : w_winner + T_ID___WIDTH'(1);
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (w_eop) begin
                    w_next_state = ARB_IDLE;
                end else begin
                    w_next_state = ARB_BUSY;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; reset abandons any locked packet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_ptr   <= w_next_ptr;
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == ARB_BUSY);

endmodule

// File: rtl/stream_grant_arbiter.sv
// Per-output arbiter bank for the crossbar: forms the request matrix from the
// input streams and runs one independent round-robin arbiter per output.
module stream_grant_arbiter
    import stream_xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    stream_grant_arbiter_if.slave  bus
);

    localparam int T_ID___WIDTH = id_width(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = id_width(M_DATA_COUNT);

    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_req;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_last_req;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] w_grant;
    logic [M_DATA_COUNT-1:0]                   w_busy;

    // Request matrix; destinations beyond the last output match no row.
    always_comb begin
        w_req      = '0;
        w_last_req = '0;
        for (int j = 0; j < M_DATA_COUNT; j++) begin
            for (int i = 0; i < S_DATA_COUNT; i++) begin
                w_req[j][i]      = bus.s_valid_i[i] && (bus.s_dest_i[i] == T_DEST_WIDTH'(j));
                w_last_req[j][i] = w_req[j][i] && bus.s_last_i[i];
            end
        end
    end

    for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
        rr_arbiter #(
            .S_DATA_COUNT (S_DATA_COUNT)
        ) u_arb (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .i_req      (w_req[j]),
            .i_last_req (w_last_req[j]),
            .i_ready    (bus.m_ready_i[j]),
            .o_grant    (w_grant[j]),
            .o_busy     (w_busy[j])
        );
    end

    assign bus.grant_o         = w_grant;
    assign bus.busy_o          = w_busy;
    assign bus.arbiter_ready_o = w_busy & bus.m_ready_i;

endmodule
